// File: rtl/program_counter_unit_pkg.sv
// Shared types and defaults for the program counter unit and its return-address stack.
package pc_pkg;

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_BRANCH,
        SEL_RET,
        SEL_TRAP
    } pc_sel_t;

    localparam int DEF_XLEN = 32;
    localparam int DEF_INC  = 4;

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// and a swap replaces the top entry (or pushes when the stack is empty).
module return_address_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            swap,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full,
    output logic            overflow,
    output logic            underflow
);

    localparam int PW = $clog2(RAS_DEPTH);

    logic [RAS_DEPTH-1:0][XLEN-1:0] mem_q, mem_d;
    logic [PW-1:0]                  ptr_q, ptr_d, top_idx;
    logic [PW:0]                    cnt_q, cnt_d;

    // ptr_q is the next free slot; once full it also points at the oldest entry.
    assign top_idx = ptr_q - PW'(1);
    assign top     = mem_q[top_idx];
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (PW+1)'(RAS_DEPTH));

    always_comb begin
        mem_d     = mem_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        overflow  = push && full;
        underflow = (pop || swap) && empty;
        if (push || (swap && empty)) begin
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_q + PW'(1);
            if (!full) cnt_d = cnt_q + (PW+1)'(1);
        end else if (swap) begin
            mem_d[top_idx] = push_data;
        end else if (pop && !empty) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage is never visible while empty, so it carries no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/program_counter_unit.sv
// Fetch-address register with trap/return/branch/sequential priority select
// and a return-address stack for call/return prediction.
module program_counter_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INC          = DEF_INC,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Stall,
    input  logic            BranchTaken,
    input  logic [XLEN-1:0] BranchTarget,
    input  logic            Call,
    input  logic            Ret,
    input  logic            TrapValid,
    input  logic [XLEN-1:0] TrapVector,
    output logic [XLEN-1:0] Address,
    output logic [XLEN-1:0] SeqAddress,
    output logic            RasEmpty,
    output logic            RasFull,
    output logic            RasOverflow,
    output logic            RasUnderflow
);

    pc_sel_t         sel;
    logic            hold;
    logic            ras_push, ras_pop, ras_swap;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty, ras_full, ras_overflow, ras_underflow;
    logic [XLEN-1:0] address_q, address_d;
    logic            ras_ovf_q, ras_ovf_d, ras_unf_q, ras_unf_d;

    assign Address      = address_q;
    assign SeqAddress   = address_q + XLEN'(INC);
    assign RasEmpty     = ras_empty;
    assign RasFull      = ras_full;
    assign RasOverflow  = ras_ovf_q;
    assign RasUnderflow = ras_unf_q;

    always_comb begin
        sel       = SEL_SEQ;
        hold      = 1'b0;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        ras_swap  = 1'b0;
        address_d = SeqAddress;
        // A trap bypasses the stall and leaves the stack untouched.
        if (TrapValid) begin
            sel = SEL_TRAP;
        end else if (Stall) begin
            hold = 1'b1;
        end else if (Ret) begin
            sel = SEL_RET;
            if (Call && BranchTaken) ras_swap = 1'b1;
            else                     ras_pop  = 1'b1;
        end else if (BranchTaken) begin
            sel      = SEL_BRANCH;
            ras_push = Call;
        end
        case (sel)
            SEL_TRAP:   address_d = TrapVector;
            SEL_RET:    address_d = ras_empty ? BranchTarget : ras_top;
            SEL_BRANCH: address_d = BranchTarget;
            default:    address_d = hold ? address_q : SeqAddress;
        endcase
        ras_ovf_d = ras_overflow;
        ras_unf_d = ras_underflow;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            address_q <= RESET_VECTOR;
            ras_ovf_q <= 1'b0;
            ras_unf_q <= 1'b0;
        end else begin
            address_q <= address_d;
            ras_ovf_q <= ras_ovf_d;
            ras_unf_q <= ras_unf_d;
        end
    end

    return_address_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (Clk),
        .rst       (Reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .swap      (ras_swap),
        .push_data (SeqAddress),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );

endmodule

// File: tb/tb_program_counter_unit.sv
// Directed bench: a reference model queues expected post-edge state, compared after each edge.
module tb_program_counter_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Stall = 1'b0, BranchTaken = 1'b0, Call = 1'b0, Ret = 1'b0, TrapValid = 1'b0;
    logic [31:0] BranchTarget = '0, TrapVector = '0;
    logic [31:0] Address, SeqAddress;
    logic        RasEmpty, RasFull, RasOverflow, RasUnderflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic        ovf;
        logic        unf;
        logic        emp;
        logic        ful;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_addr;
    logic [31:0] ms[$];

    program_counter_unit #(
        .XLEN(32), .RESET_VECTOR(32'h0), .INC(4), .RAS_DEPTH(4)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget), .Call(Call), .Ret(Ret), .TrapValid(TrapValid),
        .TrapVector(TrapVector), .Address(Address), .SeqAddress(SeqAddress),
        .RasEmpty(RasEmpty), .RasFull(RasFull), .RasOverflow(RasOverflow),
        .RasUnderflow(RasUnderflow)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Independent reference: stack as a queue, oldest entry dropped at the front.
    task automatic model(input bit st, input bit bt, input bit cl, input bit rt,
                         input bit tr, input logic [31:0] tgt, input logic [31:0] tv);
        exp_t        e;
        logic [31:0] seq;
        seq   = m_addr + 32'd4;
        e.ovf = 1'b0;
        e.unf = 1'b0;
        if (tr) m_addr = tv;
        else if (st) m_addr = m_addr;
        else if (rt && cl && bt) begin
            if (ms.size() == 0) begin
                e.unf = 1'b1; m_addr = tgt; ms.push_back(seq);
            end else begin
                m_addr = ms[ms.size()-1]; ms[ms.size()-1] = seq;
            end
        end else if (rt) begin
            if (ms.size() == 0) begin e.unf = 1'b1; m_addr = tgt; end
            else m_addr = ms.pop_back();
        end else if (bt) begin
            if (cl) begin
                if (ms.size() == 4) begin e.ovf = 1'b1; void'(ms.pop_front()); end
                ms.push_back(seq);
            end
            m_addr = tgt;
        end else m_addr = seq;
        e.addr = m_addr;
        e.emp  = (ms.size() == 0);
        e.ful  = (ms.size() == 4);
        sb.push_back(e);
    endtask

    task automatic step(input bit st, input bit bt, input bit cl, input bit rt,
                        input bit tr, input logic [31:0] tgt, input logic [31:0] tv);
        exp_t e;
        @(negedge Clk);
        Stall = st; BranchTaken = bt; Call = cl; Ret = rt; TrapValid = tr;
        BranchTarget = tgt; TrapVector = tv;
        model(st, bt, cl, rt, tr, tgt, tv);
        @(posedge Clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("addr", Address, e.addr);
            chk("seq_addr", SeqAddress, e.addr + 32'd4);
            chk("overflow", {31'd0, RasOverflow}, {31'd0, e.ovf});
            chk("underflow", {31'd0, RasUnderflow}, {31'd0, e.unf});
            chk("empty", {31'd0, RasEmpty}, {31'd0, e.emp});
            chk("full", {31'd0, RasFull}, {31'd0, e.ful});
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_addr", Address, 32'h0);
        chk("rst_empty", {31'd0, RasEmpty}, 32'd1);
        chk("rst_full", {31'd0, RasFull}, 32'd0);
        chk("rst_ovf", {31'd0, RasOverflow}, 32'd0);
        chk("rst_unf", {31'd0, RasUnderflow}, 32'd0);
        m_addr = 32'h0;
        Reset  = 1'b0;

        // Free-running sequential fetch
        step(0, 0, 0, 0, 0, 0, 0); chk("seq_4", Address, 32'h4);
        step(0, 0, 0, 0, 0, 0, 0); chk("seq_8", Address, 32'h8);
        step(0, 0, 0, 0, 0, 0, 0); chk("seq_c", Address, 32'hC);
        step(0, 0, 0, 0, 0, 0, 0); chk("seq_10", Address, 32'h10);

        // Call then return
        step(0, 1, 1, 0, 0, 32'h100, 0); chk("call_100", Address, 32'h100);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 32'hDEAD, 0); chk("ret_14", Address, 32'h14);
        chk("ret_empty", {31'd0, RasEmpty}, 32'd1);

        // Five nested calls: last one overflows, oldest return lost
        step(0, 1, 1, 0, 0, 32'h200, 0);
        step(0, 1, 1, 0, 0, 32'h300, 0);
        step(0, 1, 1, 0, 0, 32'h400, 0);
        step(0, 1, 1, 0, 0, 32'h500, 0);
        chk("full_4", {31'd0, RasFull}, 32'd1);
        step(0, 1, 1, 0, 0, 32'h600, 0);
        chk("ovf_5th", {31'd0, RasOverflow}, 32'd1);
        step(0, 0, 0, 1, 0, 0, 0); chk("lifo_0", Address, 32'h504);
        chk("ovf_clear", {31'd0, RasOverflow}, 32'd0);
        step(0, 0, 0, 1, 0, 0, 0); chk("lifo_1", Address, 32'h404);
        step(0, 0, 0, 1, 0, 0, 0); chk("lifo_2", Address, 32'h304);
        step(0, 0, 0, 1, 0, 0, 0); chk("lifo_3", Address, 32'h204);
        step(0, 0, 0, 1, 0, 32'h700, 0); chk("unf_tgt", Address, 32'h700);
        chk("unf_pulse", {31'd0, RasUnderflow}, 32'd1);

        // Coroutine swap on non-empty, then on empty
        step(0, 1, 1, 0, 0, 32'h800, 0);
        step(0, 1, 1, 1, 0, 32'h900, 0); chk("swap_top", Address, 32'h704);
        step(0, 0, 0, 1, 0, 0, 0);       chk("swap_ret", Address, 32'h804);
        step(0, 1, 1, 1, 0, 32'hA00, 0); chk("swap_empty", Address, 32'hA00);
        chk("swap_cnt1", {31'd0, RasEmpty}, 32'd0);
        step(0, 0, 0, 1, 0, 0, 0);       chk("swap_push", Address, 32'h808);

        // Stall with pending call, then trap overriding the stall
        step(0, 1, 1, 0, 0, 32'h1000, 0);
        step(1, 1, 1, 0, 0, 32'h3000, 0);
        step(1, 1, 1, 0, 0, 32'h3000, 0);
        step(1, 1, 1, 0, 0, 32'h3000, 0); chk("stall_hold", Address, 32'h1000);
        step(1, 1, 1, 1, 1, 32'h3000, 32'h80); chk("trap", Address, 32'h80);
        step(0, 0, 0, 1, 0, 0, 0); chk("post_trap_ret", Address, 32'h80C);

        // Plain branch, wrap-around, underflow then async reset
        step(0, 1, 0, 0, 0, 32'h2000, 0);
        step(0, 1, 0, 0, 0, 32'hFFFF_FFFC, 0);
        step(0, 0, 0, 0, 0, 0, 0); chk("wrap", Address, 32'h0);
        step(0, 0, 0, 1, 0, 32'h40, 0);
        Reset = 1'b1; Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h55;
        #1;
        chk("async_rst_addr", Address, 32'h0);
        chk("async_rst_unf", {31'd0, RasUnderflow}, 32'd0);
        @(posedge Clk);
        #1;
        chk("rst_held", Address, 32'h0);
        Reset = 1'b0;
        m_addr = 32'h0;
        ms.delete();
        step(0, 0, 0, 0, 0, 0, 0); chk("post_rst", Address, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_counter_unit.md
PROGRAM_COUNTER_UNIT -- requirements
Module: program_counter_unit

Interface
REQ-001 Parameter XLEN, default 32, address width in bits (≥8).
REQ-002 Parameter RESET_VECTOR, default 32'h00000000, value loaded into Address on reset.
REQ-003 Parameter INC, default 4, sequential increment in bytes.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, ≥2).
REQ-005 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-006 Reset  input  1  asynchronous, active-high reset.
REQ-007 Stall  input  1  hold Address and stack contents this cycle.
REQ-008 BranchTaken  input  1  redirect to BranchTarget.
REQ-009 BranchTarget  input  XLEN  branch, jump or call destination.
REQ-010 Call  input  1  qualified by BranchTaken: push return address, then redirect.
REQ-011 Ret  input  1  pop the stack and redirect to the popped value.
REQ-012 TrapValid  input  1  redirect to TrapVector.
REQ-013 TrapVector  input  XLEN  trap handler address.
REQ-014 Address  output  XLEN  current fetch address (registered).
REQ-015 SeqAddress  output  XLEN  Address+INC (combinational, modulo 2^XLEN).
REQ-016 RasEmpty / RasFull  output  1 each  stack occupancy 0 / RAS_DEPTH.
REQ-017 RasOverflow / RasUnderflow  output  1 each  registered one-cycle event pulses.

Function
REQ-018 Next-address priority: TrapValid > Ret > BranchTaken > sequential (Address+INC).
REQ-019 Sequential update: Address <= Address+INC; wraps from 2^XLEN-INC to 0 without a flag.
REQ-020 Redirect latency: a target presented in cycle N appears on Address after posedge N+1; there are no bubbles.
REQ-021 Stall=1 and TrapValid=0: Address, stack and count hold; all other requests are ignored; event pulses are 0.
REQ-022 TrapValid=1 overrides Stall; the stack is unchanged; the trap is taken.
REQ-023 Call push: when BranchTaken=1, Call=1, Ret=0 and the request is accepted, push SeqAddress and load BranchTarget.
REQ-024 Call=1 with BranchTaken=0 is ignored.
REQ-025 Push on full: the oldest entry is overwritten (circular); count stays RAS_DEPTH; RasOverflow pulses next cycle.
REQ-026 Ret pop: when not empty, Address <= top entry and count decrements.
REQ-027 Ret on empty: Address <= BranchTarget; count stays 0; RasUnderflow pulses next cycle.
REQ-028 Ret=1 and Call=1 in the same cycle (coroutine swap): Address <= top entry (BranchTarget if empty); the top entry is replaced by SeqAddress; count is unchanged; no overflow; underflow pulses if the stack was empty, and the swap then pushes (count becomes 1).
REQ-029 RasEmpty and RasFull are combinational from the registered count.

Reset
REQ-030 Reset assertion: immediately, independent of Clk, Address=RESET_VECTOR, count=0, pointer=0, RasOverflow=RasUnderflow=0.
REQ-031 Stack entry contents are don't-care after reset and are never observable while empty.
REQ-032 Reset mid-redirect or mid-stall discards the pending request; the first post-reset edge with Stall=0 gives Address=RESET_VECTOR+INC.

Structure
REQ-033 Shared package pc_pkg holds: enum pc_sel_t {SEL_SEQ, SEL_BRANCH, SEL_RET, SEL_TRAP}, default XLEN, and default INC.
REQ-034 The stack is a sub-module return_address_stack (params XLEN, RAS_DEPTH; ports push, pop, swap, push_data, top, empty, full, overflow, underflow).
REQ-035 The top level holds only priority select, the Address register and event registers; RTL totals 120-400 lines.

Verification
REQ-036 Reset then 3 free-running cycles -> Address 0x0, 0x4, 0x8, 0xC; RasEmpty=1.
REQ-037 At Address=0x10, Call+BranchTaken, BranchTarget=0x100 -> Address=0x100 next cycle; Ret two cycles later -> Address=0x14; RasEmpty=1.
REQ-038 Five calls with RAS_DEPTH=4 -> RasOverflow pulses once on the 5th; four Rets return the last four return addresses in LIFO order; the 5th Ret pulses RasUnderflow and loads BranchTarget.
REQ-039 Stall=1 for 3 cycles with a Call pending -> Address and count are frozen; TrapValid=1 with TrapVector=0x80 during the stall -> Address=0x80 next cycle; the stack is unchanged.
REQ-040 Address=2^32-4, no request -> Address=0x0 next cycle; Reset asserted between edges -> Address=RESET_VECTOR immediately.
